ao222_rr_arbiter: RTL and testbench

registered 3-way round-robin select generator; GNT1/GNT2/GNT3 drive the IN2/IN4/IN6 enable pins of an AO222X2-based 3:1 data mux.

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, default 8, maximum consecutive grant cycles while another requester waits (legal range 1..15).
REQ-002 CLK  input  1  rising-edge clock; the only clock.
REQ-003 RST  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 REQ1  input  1  request from source 1.
REQ-005 REQ2  input  1  request from source 2.
REQ-006 REQ3  input  1  request from source 3.
REQ-007 DONE  input  1  single-cycle release pulse from the current owner.
REQ-008 GNT1  output  1  grant to source 1; registered.
REQ-009 GNT2  output  1  grant to source 2; registered.
REQ-010 GNT3  output  1  grant to source 3; registered.
REQ-011 VALID  output  1  high when any grant is high; registered.
REQ-012 OWNER  output  2  encoded owner: 0 = none, 1..3 = granted source; registered.

Function
REQ-013 The block SHALL have two states: IDLE (no grant) and GRANT (exactly one grant high).
REQ-014 GNT1..GNT3 SHALL be one-hot or all-zero on every cycle; two high grants in the same cycle is an error.
REQ-015 VALID SHALL equal GNT1|GNT2|GNT3, and OWNER SHALL encode the same grant, on every cycle.
REQ-016 The block SHALL keep a LAST pointer (1..3) holding the most recently granted source.
REQ-017 Arbitration SHALL search circularly starting at LAST+1 (order 1->2->3->1) and pick the first asserted REQ.
REQ-018 In IDLE, if any REQ is sampled high, the block SHALL enter GRANT with the selected grant high on the next cycle (latency 1) and SHALL update LAST to that source.
REQ-019 In IDLE, if no REQ is sampled high, all outputs SHALL stay 0; DONE SHALL be ignored.
REQ-020 The block SHALL have a 4-bit hold counter; it SHALL load 1 on each new grant and increment each GRANT cycle, saturating at MAX_HOLD.
REQ-021 In GRANT, the owner SHALL be released when any of these is sampled: owner REQ low; DONE high; counter == MAX_HOLD while another REQ is high.
REQ-022 On release, the block SHALL arbitrate over the current REQs per REQ-017; the old owner therefore wins only if it is the sole requester.
REQ-023 A handover SHALL occur on the next cycle with no idle bubble: the old grant falls and the new grant rises on the same edge.
REQ-024 A re-grant to the same owner SHALL keep its GNT high and reload the counter to 1.
REQ-025 If no REQ is high at release, the block SHALL return to IDLE and all grants SHALL be 0 on the next cycle.
REQ-026 If a release condition and a new request arrive in the same cycle, the new request SHALL be included in the arbitration.
REQ-027 With no competing requester, the owner SHALL hold the grant indefinitely and the counter SHALL stay at MAX_HOLD.

Reset
REQ-028 While RST is high at a CLK edge, the block SHALL set state IDLE, LAST = 3, counter = 0, GNT1..3 = 0, VALID = 0 and OWNER = 0.
REQ-029 Reset SHALL take priority over all inputs, including a reset asserted mid-grant; the grant SHALL be 0 on the cycle after the reset edge.
REQ-030 After RST is released, the first grant SHALL go to the lowest-numbered requester, because LAST = 3.

Verification
REQ-031 Reset, then REQ1=REQ2=REQ3=1 held, DONE pulsed each owner cycle -> grants GNT1, GNT2, GNT3, GNT1, one per cycle, never overlapping.
REQ-032 REQ2 alone held for 20 cycles, MAX_HOLD=8 -> GNT2 high throughout and OWNER=2; no timeout release.
REQ-033 GNT1 active, REQ3 raised at hold count 3, MAX_HOLD=8 -> GNT1 falls and GNT3 rises on the edge after count reaches 8.
REQ-034 GNT2 active, REQ2 drops while REQ1=REQ3=0 -> next cycle all grants 0, VALID=0, OWNER=0.
REQ-035 RST asserted while GNT3 is high and all REQs are high -> next cycle outputs 0; after RST is released, GNT1 high one cycle later.
REQ-036 DONE high while in IDLE with all REQs low -> no output change; a random-stimulus one-hot assertion on GNT1..3 SHALL never fire.

---
 rtl/ao222_rr_arbiter.sv | 152 +++++++++++++++
 tb/tb_ao222_rr_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ao222_rr_arbiter.sv
// ao222_rr_arbiter: registered 3-way round-robin select generator for an AO222 3:1 mux.
// Latency: one cycle from a sampled REQ/DONE to the registered GNT/VALID/OWNER update.
// Backpressure: none; owners are released on REQ low, DONE or hold timeout while others wait.
//
// Ports:
//   CLK, RST          rising-edge clock, synchronous active-high reset
//   REQ1..REQ3        requests from sources 1..3
//   DONE              single-cycle release pulse from the current owner
//   GNT1..GNT3        registered one-hot (or all-zero) grants
//   VALID             registered OR of the grants
//   OWNER             registered encoded owner (0 = none, 1..3 = source)
module ao222_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ1,
  input  logic       REQ2,
  input  logic       REQ3,
  input  logic       DONE,
  output logic       GNT1,
  output logic       GNT2,
  output logic       GNT3,
  output logic       VALID,
  output logic [1:0] OWNER
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  logic [0:0] state, state_nxt;
  logic [1:0] last, last_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] owner_nxt;
  logic [2:0] req;
  logic [2:0] own_oh;
  logic [2:0] gnt_nxt;
  logic [1:0] pick;
  logic       owner_req;
  logic       others_req;
  logic       release_now;

  assign req = {REQ3, REQ2, REQ1};

  // Circular search starting after the last granted source; 0 means no requester.
  function automatic logic [1:0] rr_pick(input logic [1:0] lp, input logic [2:0] rq);
    logic [1:0] sel;
    sel = 2'd0;
    case (lp)
      2'd1: begin
        if (rq[1])      sel = 2'd2;
        else if (rq[2]) sel = 2'd3;
        else if (rq[0]) sel = 2'd1;
      end
      2'd2: begin
        if (rq[2])      sel = 2'd3;
        else if (rq[0]) sel = 2'd1;
        else if (rq[1]) sel = 2'd2;
      end
      default: begin
        if (rq[0])      sel = 2'd1;
        else if (rq[1]) sel = 2'd2;
        else if (rq[2]) sel = 2'd3;
      end
    endcase
    return sel;
  endfunction

  function automatic logic [2:0] to_onehot(input logic [1:0] o);
    logic [2:0] oh;
    oh = 3'b000;
    case (o)
      2'd1:    oh = 3'b001;
      2'd2:    oh = 3'b010;
      2'd3:    oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

  assign own_oh      = to_onehot(OWNER);
  assign owner_req   = |(req & own_oh);
  assign others_req  = |(req & ~own_oh);
  assign pick        = rr_pick(last, req);
  // Timeout only matters when someone else is waiting; a lone owner keeps the grant.
  assign release_now = !owner_req || DONE || ((cnt >= HOLD_MAX) && others_req);

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    owner_nxt = OWNER;
    case (state)
      ST_IDLE: begin
        if (pick != 2'd0) begin
          state_nxt = ST_GRANT;
          owner_nxt = pick;
          last_nxt  = pick;
          cnt_nxt   = 4'd1;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          // Old owner sits last in the search order, so it only wins when alone.
          if (pick != 2'd0) begin
            owner_nxt = pick;
            last_nxt  = pick;
            cnt_nxt   = 4'd1;
          end else begin
            state_nxt = ST_IDLE;
            owner_nxt = 2'd0;
            cnt_nxt   = 4'd0;
          end
        end else if (cnt < HOLD_MAX) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        owner_nxt = 2'd0;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign gnt_nxt = to_onehot(owner_nxt);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      last  <= 2'd3;
      cnt   <= 4'd0;
      OWNER <= 2'd0;
      GNT1  <= 1'b0;
      GNT2  <= 1'b0;
      GNT3  <= 1'b0;
      VALID <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      OWNER <= owner_nxt;
      GNT1  <= gnt_nxt[0];
      GNT2  <= gnt_nxt[1];
      GNT3  <= gnt_nxt[2];
      VALID <= |gnt_nxt;
    end
  end

endmodule

// File: tb/tb_ao222_rr_arbiter.sv
// tb_ao222_rr_arbiter: directed vectors plus randomised invariant checks for ao222_rr_arbiter.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable; inputs are driven just after each edge.
module tb_ao222_rr_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ1, REQ2, REQ3, DONE;
  logic       GNT1, GNT2, GNT3, VALID;
  logic [1:0] OWNER;

  int n_chk  = 0;
  int n_fail = 0;

  ao222_rr_arbiter #(.MAX_HOLD(8)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ1  (REQ1),
    .REQ2  (REQ2),
    .REQ3  (REQ3),
    .DONE  (DONE),
    .GNT1  (GNT1),
    .GNT2  (GNT2),
    .GNT3  (GNT3),
    .VALID (VALID),
    .OWNER (OWNER)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input logic r3, input logic r2, input logic r1);
    REQ3 = r3;
    REQ2 = r2;
    REQ1 = r1;
  endtask

  // Compares {VALID, OWNER, GNT3, GNT2, GNT1} against the value implied by the expected grant.
  task automatic expect_gnt(input string tag, input logic [2:0] g);
    logic [1:0] o;
    o = g[0] ? 2'd1 : g[1] ? 2'd2 : g[2] ? 2'd3 : 2'd0;
    check(tag, {2'b00, VALID, OWNER, GNT3, GNT2, GNT1}, {2'b00, |g, o, g});
  endtask

  initial begin
    logic [2:0] rs;
    logic [2:0] g;
    logic [1:0] o;

    RST  = 1'b1;
    DONE = 1'b0;
    set_req(0, 0, 0);
    step();
    step();
    expect_gnt("reset", 3'b000);

    // DONE in idle with no requests is ignored.
    RST  = 1'b0;
    DONE = 1'b1;
    step();
    expect_gnt("idle_done0", 3'b000);
    step();
    expect_gnt("idle_done1", 3'b000);
    DONE = 1'b0;

    // All requesting: first grant to source 1, then rotation with DONE each cycle.
    set_req(1, 1, 1);
    step();
    expect_gnt("rr_first_1", 3'b001);
    DONE = 1'b1;
    step();
    expect_gnt("rr_2", 3'b010);
    step();
    expect_gnt("rr_3", 3'b100);
    step();
    expect_gnt("rr_wrap_1", 3'b001);
    DONE = 1'b0;

    // Owner drops request, source 2 takes over with no bubble.
    set_req(0, 1, 0);
    step();
    expect_gnt("handover_2", 3'b010);
    // Lone requester holds far beyond MAX_HOLD.
    for (int i = 0; i < 20; i++) begin
      step();
      expect_gnt("solo_hold_2", 3'b010);
    end
    // Owner drops with nobody else requesting: back to idle.
    set_req(0, 0, 0);
    step();
    expect_gnt("drop_idle", 3'b000);

    // Timeout: GNT1 held, REQ3 arrives at count 3, handover after count reaches 8.
    set_req(0, 0, 1);
    step();
    expect_gnt("to_cnt1", 3'b001);
    step();
    expect_gnt("to_cnt2", 3'b001);
    step();
    expect_gnt("to_cnt3", 3'b001);
    set_req(1, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_gnt("to_hold_1", 3'b001);
    end
    step();
    expect_gnt("to_switch_3", 3'b100);

    // DONE with the owner as sole requester: re-grant keeps GNT3 high.
    set_req(1, 0, 0);
    DONE = 1'b1;
    step();
    expect_gnt("regrant_3", 3'b100);
    // Release and a new request in the same cycle: the newcomer wins.
    set_req(1, 1, 0);
    step();
    expect_gnt("same_cycle_2", 3'b010);
    DONE = 1'b0;
    set_req(1, 0, 0);
    step();
    expect_gnt("back_to_3", 3'b100);

    // Reset mid-grant with all requesting, then first grant goes to source 1.
    set_req(1, 1, 1);
    RST = 1'b1;
    step();
    expect_gnt("rst_midgrant", 3'b000);
    RST = 1'b0;
    step();
    expect_gnt("post_rst_1", 3'b001);

    // Random stimulus: one-hot grants, consistent VALID/OWNER, and the grant
    // (if any) always goes to a source that was requesting at the edge.
    for (int i = 0; i < 400; i++) begin
      rs   = 3'($urandom_range(0, 7));
      set_req(rs[2], rs[1], rs[0]);
      DONE = ($urandom_range(0, 3) == 0);
      step();
      g = {GNT3, GNT2, GNT1};
      o = g[0] ? 2'd1 : g[1] ? 2'd2 : g[2] ? 2'd3 : 2'd0;
      check("rand_onehot", {7'd0, ($countones(g) <= 1)}, 8'd1);
      check("rand_valid_owner", {5'd0, VALID, OWNER}, {5'd0, |g, o});
      check("rand_valid_req", {7'd0, VALID}, {7'd0, |rs});
      check("rand_gnt_in_req", {5'd0, g & rs}, {5'd0, g});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
